// File: rtl/lcd_frame_read_pkg.sv
// lcd_frame_read_pkg: shared FSM state type and bus constants for the LCD frame read path
package lcd_frame_read_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/lcd_sync_fifo.sv
// lcd_sync_fifo: show-ahead synchronous FIFO with occupancy count and synchronous flush
module lcd_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    do_pop = pop & ~empty;
    do_push = push & ((count != CW'(DEPTH)) | do_pop);
    dout = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/lcd_frame_read_master.sv
// lcd_frame_read_master: Avalon-MM pipelined read master feeding a valid/ready word stream; define LCD_FRAME_READ_MASTER_STALL_CNT_EN to add stall_cycles
module lcd_frame_read_master
  import lcd_frame_read_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef LCD_FRAME_READ_MASTER_STALL_CNT_EN
  , output logic [31:0]     stall_cycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  state_t state;
  logic [LEN_W-1:0] remaining_req, rem_nxt;
  logic [CW-1:0] pending, fifo_count;
  logic [SW-1:0] pnd_nxt, sum_nxt;
  logic [31:0] fifo_head;
  logic abort_flag, fifo_empty, accept, rsp, push, pop, credit;
  assign avm_byteenable = BYTEENABLE_ALL;
  // credit looks at post-edge occupancy, ignoring pops and responses so it can only be pessimistic
  always_comb begin
    accept = avm_read & ~avm_waitrequest;
    rsp = avm_readdatavalid & (pending != '0);
    push = rsp & ~abort_flag;
    out_valid = ~fifo_empty & ~abort_flag;
    pop = out_valid & out_ready;
    out_data = out_valid ? fifo_head : '0;
    rem_nxt = remaining_req - LEN_W'(accept);
    pnd_nxt = SW'(pending) + SW'(accept);
    sum_nxt = pnd_nxt + SW'(fifo_count);
    credit = (sum_nxt < SW'(FIFO_DEPTH)) && (pnd_nxt < SW'(MAX_PENDING));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      avm_read <= 1'b0;
      abort_flag <= 1'b0;
      avm_address <= '0;
      remaining_req <= '0;
      pending <= '0;
    end else begin
      done <= 1'b0;
      pending <= pending + CW'(accept) - CW'(rsp);
      if (accept) begin
        avm_address <= avm_address + ADDR_W'(WORD_BYTES);
        remaining_req <= rem_nxt;
      end
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          aborted <= 1'b0;
          avm_address <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
          remaining_req <= length;
          avm_read <= length != '0;
          state <= length == '0 ? FINISH : ISSUE;
        end
        ISSUE: begin
          if (abort) abort_flag <= 1'b1;
          if (!(avm_read && avm_waitrequest)) begin
            if (abort || abort_flag || rem_nxt == '0) begin
              avm_read <= 1'b0;
              state <= DRAIN;
            end else avm_read <= credit;
          end
        end
        DRAIN: begin
          if (abort) abort_flag <= 1'b1;
          if (pending == '0 && (fifo_empty || abort_flag)) state <= FINISH;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          aborted <= abort_flag;
          abort_flag <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LCD_FRAME_READ_MASTER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) stall_cycles <= '0;
    else if (avm_read && avm_waitrequest && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
  lcd_sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(abort_flag),
    .push(push),
    .pop(pop),
    .din(avm_readdata),
    .dout(fifo_head),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_lcd_frame_read_master.sv
// tb_lcd_frame_read_master: directed tests against a behavioural Avalon slave with programmable wait states
module tb_lcd_frame_read_master;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [31:0] base_addr = '0;
  logic [15:0] length = '0;
  logic busy, done, aborted, avm_read, avm_waitrequest, out_valid;
  logic [31:0] avm_address, out_data;
  logic [3:0] avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic avm_readdatavalid = 1'b0;
`ifdef LCD_FRAME_READ_MASTER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  int n_chk = 0, n_err = 0, wait_n = 0, wcnt = 0, cyc = 0;
  int n_acc, n_pop, n_done, n_rd, n_stall, hold_err, peak, bad;
  logic [31:0] acc_addr[$], pop_data[$], prev_addr;
  logic prev_stall;

  always #5 clk = ~clk;

  lcd_frame_read_master dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .aborted(aborted),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef LCD_FRAME_READ_MASTER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // slave: stalls each request for wait_n cycles, returns mem word one cycle after accept
  assign avm_waitrequest = avm_read && (wcnt < wait_n);
  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
    else if (avm_read) begin
      wcnt <= 0;
      avm_readdatavalid <= 1'b1;
      avm_readdata <= 32'hCAFE0000 + {16'h0, avm_address[17:2]};
    end
  end

  always @(negedge clk) begin
    if (avm_read) n_rd++;
    if (avm_read && avm_waitrequest) n_stall++;
    if (avm_read && !avm_waitrequest) begin
      n_acc++;
      acc_addr.push_back(avm_address);
    end
    if (out_valid && out_ready) begin
      n_pop++;
      pop_data.push_back(out_data);
    end
    if (done) n_done++;
    if (prev_stall && (!avm_read || avm_address != prev_addr)) hold_err++;
    prev_stall = avm_read && avm_waitrequest;
    prev_addr = avm_address;
    if (n_acc - n_pop > peak) peak = n_acc - n_pop;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_acc = 0; n_pop = 0; n_done = 0; n_rd = 0; n_stall = 0;
    hold_err = 0; peak = 0; prev_stall = 1'b0;
    acc_addr.delete();
    pop_data.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] len);
    base_addr = a;
    length = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (c < budget) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    if (!done) check("done_timeout", done, 1);
    tick(1);
  endtask

  function automatic logic [31:0] qa(input int i);
    return i < acc_addr.size() ? acc_addr[i] : 32'hDEADDEAD;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return i < pop_data.size() ? pop_data[i] : 32'hDEADDEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_read", avm_read, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", avm_address, 0);
    check("byteenable", avm_byteenable, 4'hF);
    reset = 1'b0;
    tick(1);

    clear_mon();
    start_xfer(32'h100, 5);
    check("t1_busy", busy, 1);
    check("t1_read_lat", avm_read, 1);
    check("t1_addr0", avm_address, 32'h100);
    wait_done(100, cyc);
    tick(5);
    check("t1_nacc", n_acc, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_addr%0d", i), qa(i), 32'h100 + 4 * i);
    check("t1_npop", n_pop, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_data%0d", i), qd(i), 32'hCAFE0040 + i);
    check("t1_ndone", n_done, 1);
    check("t1_aborted", aborted, 0);
    check("t1_busy_end", busy, 0);

    clear_mon();
    start_xfer(32'h100, 0);
    wait_done(20, cyc);
    check("t2_done_lat", cyc, 2);
    check("t2_nrd", n_rd, 0);
    check("t2_ndone", n_done, 1);

    clear_mon();
    wait_n = 3;
    start_xfer(32'h203, 4);
    check("t3_align", avm_address, 32'h200);
    wait_done(200, cyc);
    tick(2);
    check("t3_nacc", n_acc, 4);
    check("t3_nstall", n_stall, 12);
    check("t3_hold", hold_err, 0);
    check("t3_npop", n_pop, 4);
    check("t3_addr3", qa(3), 32'h20C);
    check("t3_data3", qd(3), 32'hCAFE0083);
`ifdef LCD_FRAME_READ_MASTER_STALL_CNT_EN
    check("t3_stall_cycles", stall_cycles, 12);
`endif

    clear_mon();
    wait_n = 0;
    out_ready = 1'b0;
    start_xfer(32'h0, 20);
    tick(40);
    check("t4_nacc_held", n_acc, 8);
    check("t4_read_off", avm_read, 0);
    check("t4_valid", out_valid, 1);
    check("t4_head", out_data, 32'hCAFE0000);
    check("t4_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(300, cyc);
    tick(2);
    check("t4_nacc", n_acc, 20);
    check("t4_npop", n_pop, 20);
    check("t4_peak", peak, 8);
    check("t4_addr19", qa(19), 32'h4C);
    bad = 0;
    for (int i = 0; i < 20; i++) if (qd(i) !== 32'hCAFE0000 + i) bad++;
    check("t4_order", bad, 0);

    clear_mon();
    wait_n = 1;
    start_xfer(32'h300, 100);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_hold_read", avm_read, 1);
    check("t5_hold_addr", avm_address, 32'h304);
    check("t5_valid_off", out_valid, 0);
    wait_done(100, cyc);
    check("t5_aborted", aborted, 1);
    check("t5_busy", busy, 0);
    check("t5_nacc", n_acc, 2);
    check("t5_npop", n_pop, 0);
    check("t5_hold", hold_err, 0);
    check("t5_ndone", n_done, 1);
    clear_mon();
    wait_n = 0;
    start_xfer(32'h500, 1);
    check("t5_abort_clr", aborted, 0);
    wait_done(50, cyc);
    tick(2);
    check("t5_npop2", n_pop, 1);
    check("t5_data2", qd(0), 32'hCAFE0140);
    check("t5_aborted2", aborted, 0);

    clear_mon();
    start_xfer(32'h400, 50);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_read", avm_read, 0);
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_addr", avm_address, 0);
    check("t6_done", done, 0);
    check("t6_aborted", aborted, 0);
    tick(6);
    check("t6_ndone", n_done, 0);
    clear_mon();
    start_xfer(32'h0, 2);
    wait_done(50, cyc);
    tick(2);
    check("t6_nacc", n_acc, 2);
    check("t6_addr1", qa(1), 32'h4);
    check("t6_npop", n_pop, 2);
    check("t6_data0", qd(0), 32'hCAFE0000);
    check("t6_data1", qd(1), 32'hCAFE0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
